// File: rtl/test_seq_pkg.sv
// test_seq_pkg
// Shared types and widths for the test sequencer.
//   test_seq_state_e  : sequencer FSM states (HOLD, RUN, DRAIN, PASS, FAIL)
//   test_seq_reason_e : verdict reason code as driven on fail_reason
//   HOLD_CNT_W        : width of the harness-reset hold counter (RESET_CYCLES <= 255)
//   DRAIN_CNT_W       : width of the drain counter (DRAIN_CYCLES <= 255)
package test_seq_pkg;

    localparam int HOLD_CNT_W  = 8;
    localparam int DRAIN_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_PASS  = 3'd3,
        ST_FAIL  = 3'd4
    } test_seq_state_e;

    typedef enum logic [1:0] {
        REASON_NONE       = 2'd0,
        REASON_DUT        = 2'd1,
        REASON_TIMEOUT    = 2'd2,
        REASON_DRAIN_FAIL = 2'd3
    } test_seq_reason_e;

endpackage

// File: rtl/test_seq_window.sv
// test_seq_window
// Waveform-dump window comparator. Purely combinational.
// Ports:
//   count : cycle count the window is evaluated against
//   start : first count inside the window
//   stop  : last count inside the window; 0 means the window never closes
//   hit   : count lies inside the window
module test_seq_window #(
    parameter int CNT_W = 64
) (
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] start,
    input  logic [CNT_W-1:0] stop,
    output logic             hit
);

    assign hit = (count >= start) && ((stop == '0) || (count <= stop));

endmodule

// File: rtl/test_sequencer.sv
// test_sequencer
// Test-sequencing controller between the simulation top and the harness.
// Holds the harness in reset, runs it with a cycle counter and watchdog,
// drains after success, and latches a sticky PASS/FAIL verdict with reason.
//
// Build option: TEST_SEQ_DUMP_WINDOW_EN
//   defined   : dump_en follows the cfg_dump_start..cfg_dump_stop window
//   undefined : window ports ignored, dump_en is 1 whenever reset is low
//
// Ports:
//   clock, reset         : clock and synchronous active-high reset
//   cfg_max_cycles       : watchdog limit in run cycles, 0 disables
//   cfg_dump_start/stop  : dump window bounds (stop 0 = open-ended)
//   dut_success          : harness io_success
//   dut_failure          : harness failure summary, dut_fail_code valid with it
//   dut_reset            : reset to the harness, high only in HOLD
//   running              : high in RUN and DRAIN
//   done / passed        : verdict valid (sticky) / verdict is PASS
//   fail_reason          : 0 none, 1 dut, 2 timeout, 3 failure during drain
//   fail_code            : dut_fail_code captured with the failure
//   cycle_count          : run cycles elapsed, saturating, frozen at verdict
//   dump_en              : waveform dump window
//
// done is a level-valid verdict: once high it stays high with passed,
// fail_reason and fail_code stable until reset.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int RESET_CYCLES = 16,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] cfg_max_cycles,
    input  logic [CNT_W-1:0] cfg_dump_start,
    input  logic [CNT_W-1:0] cfg_dump_stop,
    input  logic             dut_success,
    input  logic             dut_failure,
    input  logic [7:0]       dut_fail_code,
    output logic             dut_reset,
    output logic             running,
    output logic             done,
    output logic             passed,
    output logic [1:0]       fail_reason,
    output logic [7:0]       fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic             dump_en
);

    // HOLD leaves on the edge where the counter already shows RESET_CYCLES,
    // so dut_reset falls RESET_CYCLES cycles after the first edge out of reset.
    localparam logic [HOLD_CNT_W-1:0]  HOLD_LAST  = HOLD_CNT_W'(RESET_CYCLES);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST =
        DRAIN_CNT_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

    test_seq_state_e        state;
    test_seq_state_e        state_next;
    test_seq_reason_e       reason_q;
    test_seq_reason_e       reason_next;
    logic                   capture_code;
    logic [HOLD_CNT_W-1:0]  hold_cnt;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic [CNT_W-1:0]       cycle_next;
    logic                   watchdog_hit;
    logic                   window_hit;
    logic                   active_now;
    logic                   active_next;

    assign watchdog_hit = (cfg_max_cycles != '0) && (cycle_count >= cfg_max_cycles);

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_HOLD;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next   = state;
        reason_next  = reason_q;
        capture_code = 1'b0;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // failure outranks the watchdog, which outranks success
                if (dut_failure) begin
                    state_next   = ST_FAIL;
                    reason_next  = REASON_DUT;
                    capture_code = 1'b1;
                end else if (watchdog_hit) begin
                    state_next  = ST_FAIL;
                    reason_next = REASON_TIMEOUT;
                end else if (dut_success) begin
                    state_next = (DRAIN_CYCLES == 0) ? ST_PASS : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dut_failure) begin
                    state_next   = ST_FAIL;
                    reason_next  = REASON_DRAIN_FAIL;
                    capture_code = 1'b1;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_next = ST_PASS;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        dut_reset = (state == ST_HOLD);
        running   = (state == ST_RUN) || (state == ST_DRAIN);
        done      = (state == ST_PASS) || (state == ST_FAIL);
        passed    = (state == ST_PASS);
    end

    assign fail_reason = reason_q;

    // The counter only advances on edges that stay inside RUN/DRAIN, so the
    // deciding edge leaves it frozen at the last run cycle's value.
    assign active_now  = (state == ST_RUN) || (state == ST_DRAIN);
    assign active_next = (state_next == ST_RUN) || (state_next == ST_DRAIN);

    always_comb begin
        cycle_next = cycle_count;
        if ((state == ST_HOLD) && (state_next == ST_RUN)) begin
            cycle_next = CNT_W'(1);
        end else if (active_now && active_next && (cycle_count != '1)) begin
            cycle_next = cycle_count + CNT_W'(1);
        end
    end

    // dump_en is registered from the count it will sit beside, keeping the
    // window aligned with cycle_count and low for any cycle after a reset edge.
`ifdef TEST_SEQ_DUMP_WINDOW_EN
    test_seq_window #(
        .CNT_W (CNT_W)
    ) u_window (
        .count (cycle_next),
        .start (cfg_dump_start),
        .stop  (cfg_dump_stop),
        .hit   (window_hit)
    );
`else
    logic cfg_unused;
    assign cfg_unused = ^{cfg_dump_start, cfg_dump_stop};
    assign window_hit = 1'b1;
`endif

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt    <= '0;
            drain_cnt   <= '0;
            cycle_count <= '0;
            reason_q    <= REASON_NONE;
            fail_code   <= 8'h00;
            dump_en     <= 1'b0;
        end else begin
            if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
            end
            drain_cnt   <= (state == ST_DRAIN) ? drain_cnt + DRAIN_CNT_W'(1) : '0;
            cycle_count <= cycle_next;
            reason_q    <= reason_next;
            if (capture_code) begin
                fail_code <= dut_fail_code;
            end
            dump_en <= window_hit;
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer
// Directed bench for test_sequencer. A cycle-level reference model derived
// from the behaviour description is checked against every output on each
// falling edge; directed scenarios add hand-computed literal expectations.
// A second small instance (CNT_W=4, DRAIN_CYCLES=0) covers counter
// saturation and the direct RUN->PASS path.
module tb_test_sequencer;

    localparam int RESET_CYCLES = 16;
    localparam int DRAIN_CYCLES = 4;
    localparam int CNT_W        = 64;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset = 1'b1;
    logic [CNT_W-1:0] cfg_max_cycles = '0;
    logic [CNT_W-1:0] cfg_dump_start = '0;
    logic [CNT_W-1:0] cfg_dump_stop  = '0;
    logic             dut_success = 1'b0;
    logic             dut_failure = 1'b0;
    logic [7:0]       dut_fail_code = 8'h00;
    logic             dut_reset;
    logic             running;
    logic             done;
    logic             passed;
    logic [1:0]       fail_reason;
    logic [7:0]       fail_code;
    logic [CNT_W-1:0] cycle_count;
    logic             dump_en;

    test_sequencer #(
        .RESET_CYCLES (RESET_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_max_cycles (cfg_max_cycles),
        .cfg_dump_start (cfg_dump_start),
        .cfg_dump_stop  (cfg_dump_stop),
        .dut_success    (dut_success),
        .dut_failure    (dut_failure),
        .dut_fail_code  (dut_fail_code),
        .dut_reset      (dut_reset),
        .running        (running),
        .done           (done),
        .passed         (passed),
        .fail_reason    (fail_reason),
        .fail_code      (fail_code),
        .cycle_count    (cycle_count),
        .dump_en        (dump_en)
    );

    // small instance
    logic       s_reset = 1'b1;
    logic       s_success = 1'b0;
    logic       s_dut_reset;
    logic       s_running;
    logic       s_done;
    logic       s_passed;
    logic [1:0] s_fail_reason;
    logic [7:0] s_fail_code;
    logic [3:0] s_cycle_count;
    logic       s_dump_en;

    test_sequencer #(
        .RESET_CYCLES (2),
        .DRAIN_CYCLES (0),
        .CNT_W        (4)
    ) u_small (
        .clock          (clock),
        .reset          (s_reset),
        .cfg_max_cycles (4'd0),
        .cfg_dump_start (4'd0),
        .cfg_dump_stop  (4'd0),
        .dut_success    (s_success),
        .dut_failure    (1'b0),
        .dut_fail_code  (8'h00),
        .dut_reset      (s_dut_reset),
        .running        (s_running),
        .done           (s_done),
        .passed         (s_passed),
        .fail_reason    (s_fail_reason),
        .fail_code      (s_fail_code),
        .cycle_count    (s_cycle_count),
        .dump_en        (s_dump_en)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks: edges seen out of reset while the harness is held, whether the
    // test is running, remaining drain cycles, and the latched verdict.
    bit               m_valid = 1'b0;
    int               m_low;
    bit               m_run;
    bit               m_done;
    bit               m_pass;
    logic [1:0]       m_reason;
    logic [7:0]       m_code;
    logic [CNT_W-1:0] m_count;
    int               m_drain_left;
    bit               m_dump;

    always @(posedge clock) begin
        if (reset) begin
            m_valid      = 1'b1;
            m_low        = 0;
            m_run        = 1'b0;
            m_done       = 1'b0;
            m_pass       = 1'b0;
            m_reason     = 2'd0;
            m_code       = 8'h00;
            m_count      = '0;
            m_drain_left = 0;
            m_dump       = 1'b0;
        end else begin
            if (!m_run && !m_done) begin
                m_low++;
                if (m_low == RESET_CYCLES + 1) begin
                    m_run   = 1'b1;
                    m_count = 1;
                end
            end else if (m_run) begin
                if (dut_failure) begin
                    m_run    = 1'b0;
                    m_done   = 1'b1;
                    m_reason = (m_drain_left > 0) ? 2'd3 : 2'd1;
                    m_code   = dut_fail_code;
                end else if (m_drain_left == 0 && cfg_max_cycles != 0 && m_count >= cfg_max_cycles) begin
                    m_run    = 1'b0;
                    m_done   = 1'b1;
                    m_reason = 2'd2;
                end else if (m_drain_left > 0) begin
                    if (m_drain_left == 1) begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                        m_pass = 1'b1;
                    end else begin
                        m_drain_left--;
                        if (m_count != '1) m_count = m_count + 1;
                    end
                end else if (dut_success) begin
                    m_drain_left = DRAIN_CYCLES;
                    if (m_count != '1) m_count = m_count + 1;
                end else begin
                    if (m_count != '1) m_count = m_count + 1;
                end
            end
`ifdef TEST_SEQ_DUMP_WINDOW_EN
            m_dump = (m_count >= cfg_dump_start) && (cfg_dump_stop == 0 || m_count <= cfg_dump_stop);
`else
            m_dump = 1'b1;
`endif
        end
    end

    // compare process
    always @(negedge clock) begin
        if (m_valid) begin
            check("dut_reset",   dut_reset,   !m_run && !m_done);
            check("running",     running,     m_run);
            check("done",        done,        m_done);
            check("passed",      passed,      m_pass);
            check("fail_reason", fail_reason, m_reason);
            check("fail_code",   fail_code,   m_code);
            check("cycle_count", cycle_count, m_count);
            check("dump_en",     dump_en,     m_dump);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // leaves reset low just after a reset edge; the next edge is the first out of reset
    task automatic do_reset();
        reset         = 1'b1;
        dut_success   = 1'b0;
        dut_failure   = 1'b0;
        dut_fail_code = 8'h00;
        step(3);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int waited);
        waited = 0;
        while (!done && waited < limit) begin
            step(1);
            waited++;
        end
        check("done_within_bound", done, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    int w;
    int n_hi;

    initial begin
        // small instance: hold length, saturation, direct PASS
        step(2);
        s_reset = 1'b0;
        step(2);
        check("small_hold_end", s_dut_reset, 1'b1);
        step(1);
        check("small_reset_fall", s_dut_reset, 1'b0);
        check("small_first_count", s_cycle_count, 4'd1);
        step(20);
        check("small_saturate", s_cycle_count, 4'd15);
        check("small_running", s_running, 1'b1);
        s_success = 1'b1;
        step(1);
        s_success = 1'b0;
        check("small_done", s_done, 1'b1);
        check("small_passed", s_passed, 1'b1);
        check("small_count_frozen", s_cycle_count, 4'd15);
        check("small_harness_out_of_reset", s_dut_reset, 1'b0);

        // 1: success at cycle 100, drain 4
        do_reset();
        check("reset_state_count", cycle_count, 64'd0);
        check("reset_state_dut_reset", dut_reset, 1'b1);
        step(RESET_CYCLES);
        check("hold_end", dut_reset, 1'b1);
        step(1);
        check("reset_fall", dut_reset, 1'b0);
        check("first_count", cycle_count, 64'd1);
        step(99);
        check("count_100", cycle_count, 64'd100);
        dut_success = 1'b1;
        step(1);
        dut_success = 1'b0;
        check("in_drain_not_done", done, 1'b0);
        wait_done(20, w);
        check("pass_latency", 1 + w, 5);
        check("pass_passed", passed, 1'b1);
        check("pass_count", cycle_count, 64'd104);
        check("pass_reason", fail_reason, 2'd0);
        step(5);
        check("pass_sticky", done, 1'b1);

        // 2: watchdog at 50
        cfg_max_cycles = 64'd50;
        do_reset();
        wait_done(200, w);
        check("timeout_latency", w, 67);
        check("timeout_reason", fail_reason, 2'd2);
        check("timeout_count", cycle_count, 64'd50);
        check("timeout_passed", passed, 1'b0);
        cfg_max_cycles = 64'd0;

        // 3: failure and success together
        do_reset();
        step(RESET_CYCLES + 1 + 9);
        check("pre_fail_count", cycle_count, 64'd10);
        dut_failure   = 1'b1;
        dut_fail_code = 8'h5A;
        dut_success   = 1'b1;
        step(1);
        dut_failure   = 1'b0;
        dut_success   = 1'b0;
        dut_fail_code = 8'h00;
        check("dutfail_done", done, 1'b1);
        check("dutfail_reason", fail_reason, 2'd1);
        check("dutfail_code", fail_code, 8'h5A);
        check("dutfail_count", cycle_count, 64'd10);

        // 4: failure two cycles into drain
        do_reset();
        step(RESET_CYCLES + 1 + 4);
        dut_success = 1'b1;
        step(1);
        dut_success = 1'b0;
        step(1);
        dut_failure   = 1'b1;
        dut_fail_code = 8'h33;
        step(1);
        dut_failure   = 1'b0;
        dut_fail_code = 8'h00;
        check("drainfail_done", done, 1'b1);
        check("drainfail_reason", fail_reason, 2'd3);
        check("drainfail_code", fail_code, 8'h33);
        check("drainfail_count", cycle_count, 64'd7);

        // 5: dump window 10..20
        cfg_dump_start = 64'd10;
        cfg_dump_stop  = 64'd20;
        do_reset();
        n_hi = 0;
        for (int i = 0; i < RESET_CYCLES + 1 + 39; i++) begin
            step(1);
            if (dump_en) n_hi++;
        end
        check("window_end_count", cycle_count, 64'd40);
`ifdef TEST_SEQ_DUMP_WINDOW_EN
        check("window_high_cycles", n_hi, 11);
`else
        check("window_high_cycles", n_hi, RESET_CYCLES + 1 + 39);
`endif
        dut_success = 1'b1;
        step(1);
        dut_success = 1'b0;
        wait_done(20, w);
        cfg_dump_start = 64'd0;
        cfg_dump_stop  = 64'd0;

        // 6: reset pulse at cycle 30, full re-run
        do_reset();
        step(RESET_CYCLES + 1 + 29);
        check("pre_pulse_count", cycle_count, 64'd30);
        reset = 1'b1;
        step(1);
        check("pulse_dut_reset", dut_reset, 1'b1);
        check("pulse_running", running, 1'b0);
        check("pulse_done", done, 1'b0);
        check("pulse_passed", passed, 1'b0);
        check("pulse_reason", fail_reason, 2'd0);
        check("pulse_code", fail_code, 8'h00);
        check("pulse_count", cycle_count, 64'd0);
        check("pulse_dump_en", dump_en, 1'b0);
        reset = 1'b0;
        step(RESET_CYCLES);
        check("rerun_hold_end", dut_reset, 1'b1);
        step(1);
        check("rerun_reset_fall", dut_reset, 1'b0);
        check("rerun_first_count", cycle_count, 64'd1);
        dut_success = 1'b1;
        step(1);
        dut_success = 1'b0;
        wait_done(20, w);
        check("rerun_passed", passed, 1'b1);
        check("rerun_count", cycle_count, 64'd5);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
